// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-RAM port between the pipelined core and a
//   debug/loader master. The core has default priority. A starvation counter
//   forces a debug slot after MAX_WAIT consecutive denied debug cycles, and a
//   lock mode gives the debug master exclusive ownership for bursts.
//
// Ports
//   CLK, RESET (async, active high), CLEAR (sync clear)
//   c_addr/c_wdata/c_we/c_re -> core request;  c_rdata/c_stall -> core response
//   d_req/d_we/d_lock/d_addr/d_wdata -> debug request
//   d_gnt/d_rvalid/d_rdata -> debug response
//   daddr/ddata_w/MemWrite/MemRead -> RAM;  ddata_r <- RAM (1-cycle read latency)
module dmem_arbiter #(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 32,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CLEAR,
  input  logic [ADDR_SIZE-1:0] c_addr,
  input  logic [DATA_SIZE-1:0] c_wdata,
  input  logic                 c_we,
  input  logic                 c_re,
  output logic [DATA_SIZE-1:0] c_rdata,
  output logic                 c_stall,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic                 d_lock,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [DATA_SIZE-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [DATA_SIZE-1:0] d_rdata,
  output logic [ADDR_SIZE-1:0] daddr,
  output logic [DATA_SIZE-1:0] ddata_w,
  output logic                 MemWrite,
  output logic                 MemRead,
  input  logic [DATA_SIZE-1:0] ddata_r
);

  typedef enum logic {NORMAL = 1'b0, LOCKED = 1'b1} mode_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  mode_t      mode, mode_next;
  logic [3:0] starve_cnt, starve_next;
  logic       rd_dbg, rd_dbg_next;
  logic       c_req, core_granted, debug_granted;

  assign c_req = c_we | c_re;

  // Grant decision and RAM mux. While RESET is high nothing is granted, so
  // the RAM controls drop to zero immediately rather than at the next edge.
  always_comb begin
    core_granted  = 1'b0;
    debug_granted = 1'b0;
    daddr         = '0;
    ddata_w       = '0;
    MemWrite      = 1'b0;
    MemRead       = 1'b0;
    mode_next     = mode;
    starve_next   = starve_cnt;

    if (!RESET) begin
      case (mode)
        NORMAL: begin
          if (starve_cnt == MAX_CNT && d_req) debug_granted = 1'b1;
          else if (c_req)                     core_granted  = 1'b1;
          else if (d_req)                     debug_granted = 1'b1;
        end
        LOCKED: debug_granted = d_req;
        default: ;
      endcase
    end

    if (core_granted) begin
      daddr    = c_addr;
      ddata_w  = c_wdata;
      MemWrite = c_we;
      MemRead  = c_re & ~c_we;   // simultaneous we/re is treated as a write
    end else if (debug_granted) begin
      daddr    = d_addr;
      ddata_w  = d_wdata;
      MemWrite = d_we;
      MemRead  = ~d_we;
    end

    if (debug_granted || !d_req)  starve_next = 4'd0;
    else if (starve_cnt < MAX_CNT) starve_next = starve_cnt + 4'd1;

    case (mode)
      NORMAL:  if (d_req && d_lock && debug_granted) mode_next = LOCKED;
      LOCKED:  if (!d_lock) mode_next = NORMAL;
      default: mode_next = NORMAL;
    endcase
  end

  assign rd_dbg_next = debug_granted & ~d_we;

  assign c_stall  = c_req & ~core_granted;
  assign d_gnt    = d_req & debug_granted;
  assign d_rvalid = rd_dbg;
  assign d_rdata  = rd_dbg ? ddata_r : '0;
  assign c_rdata  = ddata_r;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mode       <= NORMAL;
      starve_cnt <= 4'd0;
      rd_dbg     <= 1'b0;
    end else if (CLEAR) begin
      mode       <= NORMAL;
      starve_cnt <= 4'd0;
      rd_dbg     <= 1'b0;
    end else begin
      mode       <= mode_next;
      starve_cnt <= starve_next;
      rd_dbg     <= rd_dbg_next;
    end
  end

endmodule
